pingpong_merge: RTL and testbench

- Recombines the two 136-bit ping-pong lanes into one ordered 136-bit stream. Lane 1 is the flag-high path and lane 2 is the flag-low path.
- Alternates whole frames of FRAME_LEN beats: one frame from lane 1, then one frame from lane 2, and so on.
- Sits downstream of the two FFT buffer banks and in front of the output serializer.
- Has valid/ready handshakes on both inputs and on the output, and one registered output stage.

---
 rtl/pingpong_merge.sv | 92 +++++++++
 tb/tb_pingpong_merge.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_merge.sv
// pingpong_merge: recombines the two ping-pong FFT lanes into one ordered
// stream. Whole frames of FRAME_LEN beats alternate, lane 1 first, through a
// single registered output stage with valid/ready on every side.
module pingpong_merge #(
  parameter int DATA_W    = 136,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              valid_in_1,
  output logic              ready_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic              valid_in_2,
  output logic              ready_in_2,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              merge_flag,
  output logic              frame_done
);

  typedef enum logic {SEL1 = 1'b0, SEL2 = 1'b1} sel_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             accept;
  logic             last_beat;

  // Lane select and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL1;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // Next lane/count: restart wins, otherwise advance on each accepted beat and swap lanes at frame end.
  always_comb begin
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (sync_clr) begin
      sel_d = SEL1;
      cnt_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        cnt_d = '0;
        sel_d = (sel_q == SEL1) ? SEL2 : SEL1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Handshake decode: only the selected lane is offered a ready, and only when the output slot is free.
  always_comb begin
    load       = enable & ~sync_clr & (~valid_out | ready_out);
    ready_in_1 = load & (sel_q == SEL1);
    ready_in_2 = load & (sel_q == SEL2);
    accept     = (ready_in_1 & valid_in_1) | (ready_in_2 & valid_in_2);
    last_beat  = (cnt_q == LAST_BEAT);
  end

  // Output stage: load on accept (replacing a word being drained), else drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      merge_flag <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & last_beat;
      if (accept) begin
        data_out   <= (sel_q == SEL1) ? data_in_1 : data_in_2;
        merge_flag <= (sel_q == SEL1);
        valid_out  <= 1'b1;
      end else if (ready_out) begin
        valid_out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_merge.sv
// tb_pingpong_merge: directed stimulus for pingpong_merge with a scoreboard.
// Stimulus pushes the expected output order; a monitor pops on each output
// transfer and also checks the frame_done pulse against the frame position.
module tb_pingpong_merge;

  localparam int DATA_W = 136;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              f;
    logic              last;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              sync_clr;
  logic [DATA_W-1:0] data_in_1;
  logic              valid_in_1;
  logic              ready_in_1;
  logic [DATA_W-1:0] data_in_2;
  logic              valid_in_2;
  logic              ready_in_2;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_out;
  logic              merge_flag;
  logic              frame_done;

  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] q2[$];
  exp_t              ref_q[$];
  logic              gate1, gate2;
  int                n1, n2;
  int                n_cmp, n_err;
  int                fd_count;

  pingpong_merge #(.DATA_W(DATA_W), .FRAME_LEN(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sync_clr   (sync_clr),
    .data_in_1  (data_in_1),
    .valid_in_1 (valid_in_1),
    .ready_in_1 (ready_in_1),
    .data_in_2  (data_in_2),
    .valid_in_2 (valid_in_2),
    .ready_in_2 (ready_in_2),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .merge_flag (merge_flag),
    .frame_done (frame_done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Drive lane sources from their queues; each lane presents its head word.
  task automatic applyStimulus();
    valid_in_1 = gate1 && (q1.size() > 0);
    data_in_1  = (q1.size() > 0) ? q1[0] : '0;
    valid_in_2 = gate2 && (q2.size() > 0);
    data_in_2  = (q2.size() > 0) ? q2[0] : '0;
    #1;
  endtask

  // One clock: sample handshakes mid-cycle, retire accepted source words after the edge.
  task automatic cycle();
    logic hs1, hs2;
    @(negedge clk);
    hs1 = rst_n && valid_in_1 && ready_in_1;
    hs2 = rst_n && valid_in_2 && ready_in_2;
    @(posedge clk);
    #1;
    if (hs1) begin void'(q1.pop_front()); n1++; end
    if (hs2) begin void'(q2.pop_front()); n2++; end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      cycle();
    end
  endtask

  // Queue one 16-beat frame on a lane; only the first nexp words are expected out.
  task automatic pushFrame(input int lane, input int base, input int nexp);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (lane == 1) q1.push_back(DATA_W'(base + i));
      else           q2.push_back(DATA_W'(base + i));
      if (i < nexp) begin
        e.d    = DATA_W'(base + i);
        e.f    = (lane == 1);
        e.last = (i == 15);
        ref_q.push_back(e);
      end
    end
  endtask

  task automatic waitCount(input int lane, input int target, input string name);
    int budget;
    budget = 0;
    while ((((lane == 1) ? n1 : n2) < target) && (budget < 200)) begin
      step(1);
      budget++;
    end
    checkInt(name, (lane == 1) ? n1 : n2, target);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while ((ref_q.size() > 0) && (budget < 400)) begin
      step(1);
      budget++;
    end
    checkInt(name, ref_q.size(), 0);
  endtask

  // Monitor: pop expected word on each output transfer; frame_done must pulse only on a fresh last beat.
  initial begin
    logic prev_v, prev_r, new_word, exp_fd;
    exp_t e;
    prev_v = 1'b0;
    prev_r = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_r = 1'b1;
      end else begin
        new_word = valid_out && (!prev_v || prev_r);
        exp_fd   = new_word && (ref_q.size() > 0) && ref_q[0].last;
        if (frame_done) fd_count++;
        checkBit("frame_done", frame_done, exp_fd);
        if (valid_out && ready_out) begin
          if (ref_q.size() == 0) begin
            checkOutput("unexpected_word", data_out, '0);
            checkBit("unexpected_valid", valid_out, 1'b0);
          end else begin
            e = ref_q.pop_front();
            checkOutput("data_out", data_out, e.d);
            checkBit("merge_flag", merge_flag, e.f);
          end
        end
        prev_v = valid_out;
        prev_r = ready_out;
      end
    end
  end

  // Directed test sequence.
  initial begin
    int fd0, gaps;
    n_cmp = 0; n_err = 0; fd_count = 0;
    n1 = 0; n2 = 0;
    gate1 = 1'b0; gate2 = 1'b0;
    rst_n = 1'b0; enable = 1'b1; sync_clr = 1'b0; ready_out = 1'b1;
    valid_in_1 = 1'b0; valid_in_2 = 1'b0;
    data_in_1 = '0; data_in_2 = '0;

    // Reset state
    step(2);
    checkOutput("rst_data_out", data_out, '0);
    checkBit("rst_valid_out", valid_out, 1'b0);
    checkBit("rst_merge_flag", merge_flag, 1'b0);
    checkBit("rst_frame_done", frame_done, 1'b0);
    checkBit("rst_ready_in_1", ready_in_1, 1'b1);
    checkBit("rst_ready_in_2", ready_in_2, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Test 1: both lanes always valid, two full rounds
    $display("[TB] test 1: continuous alternation");
    n1 = 0; n2 = 0; fd0 = fd_count;
    for (int r = 0; r < 2; r++) begin
      pushFrame(1, 'h100, 16);
      pushFrame(2, 'h200, 16);
    end
    gate1 = 1'b1; gate2 = 1'b1;
    step(1);
    checkBit("t1_first_valid", valid_out, 1'b1);
    checkOutput("t1_first_data", data_out, DATA_W'('h100));
    gaps = 0;
    for (int i = 0; i < 200 && ref_q.size() > 0; i++) begin
      step(1);
      if (ref_q.size() > 0 && !valid_out) gaps++;
    end
    checkInt("t1_gaps", gaps, 0);
    checkInt("t1_drain", ref_q.size(), 0);
    checkInt("t1_frame_done_count", fd_count - fd0, 4);

    // Test 2: lane 1 stalls for beats 5-9, lane 2 must wait
    $display("[TB] test 2: stalled lane blocks the other");
    n1 = 0; n2 = 0;
    pushFrame(1, 'h300, 16);
    pushFrame(2, 'h400, 16);
    waitCount(1, 5, "t2_reach5");
    gate1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkBit("t2_ready_in_2", ready_in_2, 1'b0);
      cycle();
    end
    checkInt("t2_no_lane2", n2, 0);
    gate1 = 1'b1;
    drain("t2_drain");

    // Test 3: output backpressure for three cycles
    $display("[TB] test 3: backpressure");
    n1 = 0; n2 = 0;
    pushFrame(1, 'h500, 16);
    pushFrame(2, 'h600, 16);
    waitCount(1, 4, "t3_reach4");
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t3_hold_data", data_out, DATA_W'('h503));
      checkBit("t3_hold_flag", merge_flag, 1'b1);
      checkBit("t3_hold_valid", valid_out, 1'b1);
      checkBit("t3_ready_in_1", ready_in_1, 1'b0);
      cycle();
    end
    checkInt("t3_no_accept", n1, 4);
    ready_out = 1'b1;
    drain("t3_drain");

    // Test 4: sync_clr at lane 2 beat 7
    $display("[TB] test 4: synchronous restart");
    n1 = 0; n2 = 0;
    pushFrame(1, 'h700, 16);
    pushFrame(2, 'h800, 7);
    waitCount(2, 7, "t4_reach7");
    fd0 = fd_count;
    sync_clr = 1'b1;
    applyStimulus();
    checkBit("t4_ready_in_2_clr", ready_in_2, 1'b0);
    cycle();
    sync_clr = 1'b0;
    checkInt("t4_no_accept", n2, 7);
    checkBit("t4_no_frame_done", frame_done, 1'b0);
    q2.delete();
    pushFrame(1, 'h900, 16);
    pushFrame(2, 'hA00, 16);
    drain("t4_drain");
    checkInt("t4_frame_done_count", fd_count - fd0, 2);

    // Test 5: enable low for 4 cycles at cnt=10
    $display("[TB] test 5: enable freeze");
    n1 = 0; n2 = 0;
    pushFrame(1, 'hB00, 16);
    pushFrame(2, 'hC00, 16);
    waitCount(1, 10, "t5_reach10");
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkBit("t5_ready_in_1", ready_in_1, 1'b0);
      cycle();
    end
    checkInt("t5_no_accept", n1, 10);
    enable = 1'b1;
    drain("t5_drain");

    // Test 6: asynchronous reset mid-frame with a held word
    $display("[TB] test 6: async reset mid-frame");
    n1 = 0; n2 = 0;
    pushFrame(1, 'hD00, 3);
    waitCount(1, 4, "t6_reach4");
    ready_out = 1'b0;
    applyStimulus();
    #1 rst_n = 1'b0;
    #1;
    checkBit("t6_rst_valid", valid_out, 1'b0);
    checkOutput("t6_rst_data", data_out, '0);
    checkBit("t6_rst_flag", merge_flag, 1'b0);
    gate1 = 1'b0;
    q1.delete();
    step(2);
    checkInt("t6_ref_empty", ref_q.size(), 0);
    rst_n = 1'b1;
    ready_out = 1'b1;
    gate1 = 1'b1;
    n1 = 0; n2 = 0;
    pushFrame(1, 'hF00, 16);
    pushFrame(2, 'h1000, 16);
    step(1);
    checkOutput("t6_restart_data", data_out, DATA_W'('hF00));
    checkBit("t6_restart_flag", merge_flag, 1'b1);
    drain("t6_drain");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
